muldiv_unit: RTL and testbench

Parametrised, multi-cycle RV32M/RV64M multiply–divide unit for the execute stage. It replaces the separate edge-triggered divider and free-running multiplier with a single valid/ready engine. It accepts one M-extension operation at a time, computes all eight funct3 variants with RISC-V sign and corner-case semantics, and returns the result with its destination tag. The hazard unit stalls the pipe on `in_ready`/`out_valid`. `flush` aborts the operation on a branch redirect.

---
 rtl/muldiv_unit.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide engine with valid/ready handshakes.
// Optional MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow divides finish at accept.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned TAGW = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [TAGW-1:0] tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int unsigned CW = $clog2(XLEN);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

  logic [1:0]        state, stateNxt;
  logic [CW-1:0]     cnt, cntNxt;
  logic [2:0]        opReg, opNxt;
  logic [TAGW-1:0]   tagReg, tagNxt;
  logic [XLEN-1:0]   magA, magANxt, magB, magBNxt;
  logic              signA, signANxt, signB, signBNxt;
  logic              bZero, bZeroNxt, ovf, ovfNxt;
  logic [2*XLEN-1:0] acc, accNxt;
  logic [XLEN-1:0]   rem, remNxt;
  logic              outValidNxt, busyNxt;
  logic [XLEN-1:0]   outResultNxt;
  logic [TAGW-1:0]   outTagNxt;

  // Operand decode at accept: signedness, magnitudes and divide corner cases
  logic            accept, aSigned, bSigned, negA, negB, divZeroIn, ovfIn;
  logic [XLEN-1:0] magAIn, magBIn;

  assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign aSigned   = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign bSigned   = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign negA      = aSigned && a[XLEN-1];
  assign negB      = bSigned && b[XLEN-1];
  assign magAIn    = negA ? ({XLEN{1'b0}} - a) : a;
  assign magBIn    = negB ? ({XLEN{1'b0}} - b) : b;
  assign divZeroIn = op[2] && (b == {XLEN{1'b0}});
  assign ovfIn     = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == ALL_ONES);

`ifdef MULDIV_EARLY_OUT_EN
  logic [XLEN-1:0] earlyRes;
  assign earlyRes = divZeroIn ? (op[1] ? a : ALL_ONES) : (op[1] ? {XLEN{1'b0}} : MIN_NEG);
`endif

  // One shift-add or restoring-subtract step per CALC cycle
  logic [XLEN:0] mulSum, divShift, divDiff;

  assign mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, magB} : {(XLEN+1){1'b0}});
  assign divShift = {rem, acc[XLEN-1]};
  assign divDiff  = divShift - {1'b0, magB};

  // Sign application, half selection and RISC-V divide corrections
  logic [2*XLEN-1:0] prodS;
  logic [XLEN-1:0]   quoS, remS, aOrig, fixRes;

  assign prodS = (signA ^ signB) ? ({(2*XLEN){1'b0}} - acc) : acc;
  assign quoS  = (signA ^ signB) ? ({XLEN{1'b0}} - acc[XLEN-1:0]) : acc[XLEN-1:0];
  assign remS  = signA ? ({XLEN{1'b0}} - rem) : rem;
  assign aOrig = signA ? ({XLEN{1'b0}} - magA) : magA;

  always_comb begin
    fixRes = opReg[1] ? remS : quoS;
    if (!opReg[2]) begin
      fixRes = (opReg[1:0] == 2'b00) ? prodS[XLEN-1:0] : prodS[2*XLEN-1:XLEN];
    end else if (bZero) begin
      fixRes = opReg[1] ? aOrig : ALL_ONES;
    end else if (ovf) begin
      fixRes = opReg[1] ? {XLEN{1'b0}} : MIN_NEG;
    end
  end

  // Next-state and output logic
  always_comb begin
    stateNxt     = state;
    cntNxt       = cnt;
    opNxt        = opReg;
    tagNxt       = tagReg;
    magANxt      = magA;
    magBNxt      = magB;
    signANxt     = signA;
    signBNxt     = signB;
    bZeroNxt     = bZero;
    ovfNxt       = ovf;
    accNxt       = acc;
    remNxt       = rem;
    outValidNxt  = out_valid;
    outResultNxt = out_result;
    outTagNxt    = out_tag;

    case (state)
      CALC: begin
        if (opReg[2]) begin
          accNxt = {acc[2*XLEN-1:XLEN], acc[XLEN-2:0], ~divDiff[XLEN]};
          remNxt = divDiff[XLEN] ? divShift[XLEN-1:0] : divDiff[XLEN-1:0];
        end else begin
          accNxt = {mulSum, acc[XLEN-1:1]};
        end
        cntNxt = cnt + CW'(1);
        if (cnt == CW'(XLEN - 1)) stateNxt = FIX;
      end
      FIX: begin
        outResultNxt = fixRes;
        outTagNxt    = tagReg;
        outValidNxt  = 1'b1;
        stateNxt     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          outValidNxt = 1'b0;
          stateNxt    = IDLE;
        end
      end
      default: ;
    endcase

    // An accept in DONE overrides the return to IDLE (back-to-back)
    if (accept) begin
      opNxt    = op;
      tagNxt   = tag;
      magANxt  = magAIn;
      magBNxt  = magBIn;
      signANxt = negA;
      signBNxt = negB;
      bZeroNxt = divZeroIn;
      ovfNxt   = ovfIn;
      accNxt   = {{XLEN{1'b0}}, magAIn};
      remNxt   = {XLEN{1'b0}};
      cntNxt   = {CW{1'b0}};
      stateNxt = CALC;
`ifdef MULDIV_EARLY_OUT_EN
      if (divZeroIn || ovfIn) begin
        stateNxt     = DONE;
        outValidNxt  = 1'b1;
        outResultNxt = earlyRes;
        outTagNxt    = tag;
      end
`endif
    end

    if (flush) begin
      stateNxt    = IDLE;
      outValidNxt = 1'b0;
    end

    busyNxt = (stateNxt != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= {CW{1'b0}};
      opReg      <= 3'b000;
      tagReg     <= {TAGW{1'b0}};
      magA       <= {XLEN{1'b0}};
      magB       <= {XLEN{1'b0}};
      signA      <= 1'b0;
      signB      <= 1'b0;
      bZero      <= 1'b0;
      ovf        <= 1'b0;
      acc        <= {(2*XLEN){1'b0}};
      rem        <= {XLEN{1'b0}};
      out_valid  <= 1'b0;
      out_result <= {XLEN{1'b0}};
      out_tag    <= {TAGW{1'b0}};
      busy       <= 1'b0;
    end else begin
      state      <= stateNxt;
      cnt        <= cntNxt;
      opReg      <= opNxt;
      tagReg     <= tagNxt;
      magA       <= magANxt;
      magB       <= magBNxt;
      signA      <= signANxt;
      signB      <= signBNxt;
      bZero      <= bZeroNxt;
      ovf        <= ovfNxt;
      acc        <= accNxt;
      rem        <= remNxt;
      out_valid  <= outValidNxt;
      out_result <= outResultNxt;
      out_tag    <= outTagNxt;
      busy       <= busyNxt;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned TAGW = 5;
  localparam int LAT = XLEN + 2;

  logic            CLK = 1'b0;
  logic            RST;
  logic            inValid;
  logic            inReady;
  logic [2:0]      opIn;
  logic [XLEN-1:0] aIn, bIn;
  logic [TAGW-1:0] tagIn;
  logic            flush;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] outResult;
  logic [TAGW-1:0] outTag;
  logic            busy;

  int testCnt = 0;
  int failCnt = 0;

  muldiv_unit #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .op         (opIn),
    .a          (aIn),
    .b          (bIn),
    .tag        (tagIn),
    .flush      (flush),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_result (outResult),
    .out_tag    (outTag),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    testCnt++;
    assert (got === exp) else begin
      failCnt++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with plain 64-bit arithmetic
  function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] x,
                                           input logic [31:0] y);
    longint sx, sy, uy;
    logic [63:0] p;
    int qi;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    uy = longint'({32'd0, y});
    p  = 64'd0;
    case (f3)
      3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      3'd1: begin p = 64'(sx * sy); return p[63:32]; end
      3'd2: begin p = 64'(sx * uy); return p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        qi = int'(sx / sy);
        return 32'(qi);
      end
      3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        qi = int'(sx % sy);
        return 32'(qi);
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic int expLat(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (f3[2] && (y == 32'd0 || (!f3[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
`endif
    return LAT;
  endfunction

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // Offer one op and return just after its accept edge
  task automatic issue(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                       input logic [TAGW-1:0] t);
    int n;
    opIn = f3; aIn = x; bIn = y; tagIn = t; inValid = 1'b1;
    #1;
    n = 0;
    while (!inReady && n < 100) begin
      cycle();
      n++;
    end
    check("issue_ready", inReady, 1'b1);
    cycle();
    inValid = 1'b0;
  endtask

  // Latency counts edges from accept to the edge that first sees out_valid
  task automatic waitResult(input string name, input logic [31:0] exp, input logic [TAGW-1:0] t,
                            input int lat);
    int n;
    n = 1;
    while (!outValid && n < 200) begin
      cycle();
      n++;
    end
    check({name, "_lat"}, 64'(n), 64'(lat));
    check(name, outResult, exp);
    check({name, "_tag"}, outTag, t);
  endtask

  task automatic runOp(input string name, input logic [2:0] f3, input logic [31:0] x,
                       input logic [31:0] y, input logic [TAGW-1:0] t);
    outReady = 1'b1;
    issue(f3, x, y, t);
    waitResult(name, refModel(f3, x, y), t, expLat(f3, x, y));
    cycle();
    check({name, "_drop"}, outValid, 1'b0);
  endtask

  initial begin
    logic [31:0] held, x, y;
    logic [2:0]  f3;
    logic        seen;

    RST = 1'b1; inValid = 1'b0; opIn = 3'd0; aIn = '0; bIn = '0; tagIn = '0;
    flush = 1'b0; outReady = 1'b0;
    repeat (3) cycle();
    check("rst_out_valid", outValid, 1'b0);
    check("rst_out_result", outResult, 32'd0);
    check("rst_out_tag", outTag, 5'd0);
    check("rst_busy", busy, 1'b0);
    RST = 1'b0;
    #1;
    check("rst_in_ready", inReady, 1'b1);

    // Multiply family on all-ones operands
    runOp("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    runOp("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    runOp("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    runOp("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);

    // Signed and unsigned divide of -7 by 2
    runOp("div_m7", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5);
    runOp("rem_m7", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6);
    runOp("divu_m7", 3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7);

    // Divide-by-zero and signed overflow
    runOp("divu_z", 3'd5, 32'd7, 32'd0, 5'd8);
    runOp("remu_z", 3'd7, 32'd7, 32'd0, 5'd9);
    runOp("div_z", 3'd4, 32'hFFFF_FFF9, 32'd0, 5'd10);
    runOp("rem_z", 3'd6, 32'hFFFF_FFF9, 32'd0, 5'd11);
    runOp("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    runOp("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

    // Random ops with injected corner operands
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case (i % 6)
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'd1;
        default: ;
      endcase
      runOp($sformatf("rand%0d", i), f3, x, y, 5'(i));
    end

    // Backpressure, then back-to-back accept on the releasing edge
    outReady = 1'b0;
    issue(3'd5, 32'd1000, 32'd7, 5'd20);
    waitResult("bp_first", refModel(3'd5, 32'd1000, 32'd7), 5'd20, LAT);
    held = outResult;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_hold_result", outResult, held);
      check("bp_hold_valid", outValid, 1'b1);
      check("bp_in_ready", inReady, 1'b0);
    end
    outReady = 1'b1;
    opIn = 3'd3; aIn = 32'h1234_5678; bIn = 32'h9ABC_DEF0; tagIn = 5'd21; inValid = 1'b1;
    #1;
    check("b2b_in_ready", inReady, 1'b1);
    cycle();
    inValid = 1'b0;
    check("b2b_old_taken", outValid, 1'b0);
    check("b2b_busy", busy, 1'b1);
    waitResult("b2b_second", refModel(3'd3, 32'h1234_5678, 32'h9ABC_DEF0), 5'd21, LAT);
    cycle();

    // Flush during CALC cycle 10
    issue(3'd0, 32'd12345, 32'd678, 5'd9);
    repeat (9) cycle();
    flush = 1'b1;
    #1;
    check("flush_in_ready_low", inReady, 1'b0);
    cycle();
    flush = 1'b0;
    #1;
    check("flush_in_ready", inReady, 1'b1);
    check("flush_busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (outValid) seen = 1'b1;
    end
    check("flush_no_result", seen, 1'b0);

    // Flush together with in_valid must not accept
    opIn = 3'd0; aIn = 32'd3; bIn = 32'd4; tagIn = 5'd22; inValid = 1'b1; flush = 1'b1;
    #1;
    check("flush_accept_ready", inReady, 1'b0);
    cycle();
    inValid = 1'b0; flush = 1'b0;
    check("flush_accept_busy", busy, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (outValid) seen = 1'b1;
    end
    check("flush_accept_no_result", seen, 1'b0);

    // Reset in the middle of CALC
    runOp("pre_rst", 3'd0, 32'd6, 32'd7, 5'd23);
    issue(3'd0, 32'hDEAD_BEEF, 32'h1357_9BDF, 5'd7);
    repeat (5) cycle();
    RST = 1'b1;
    cycle();
    check("midrst_out_valid", outValid, 1'b0);
    check("midrst_out_result", outResult, 32'd0);
    check("midrst_out_tag", outTag, 5'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", inReady, 1'b1);
    RST = 1'b0;
    runOp("post_rst_mul", 3'd0, 32'd3, 32'd5, 5'd15);
    check("post_rst_mul_15", outResult, 32'd15);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
